sprite_scan_ctrl: RTL and testbench
===================================

Name: sprite_scan_ctrl

Overview:
- Per-scanline sprite evaluation sequencer that owns the read port of the 256x32 sprite attribute RAM.
- On each line-start pulse it walks sprite entries 0..NUM_SPRITES-1 (2 words each) and tests Z-enable and vertical intersection with the current line.
- Each hit is emitted to the sprite line renderer over a valid/ready stream.
- Sits between the sprite attribute RAM and the sprite line renderer in the sprite engine.

Parameters:
- NUM_SPRITES, 128, sprites scanned per line (1..128); entry n occupies RAM words 2n and 2n+1.
- MAX_HITS, 64, maximum hits emitted per line (1..NUM_SPRITES).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- line_start_i  in  1  single-cycle pulse: begin scan for line_i.
- line_i  in  10  scanline number, sampled on line_start_i.
- ram_rd_addr_o  out  8  sprite RAM read address.
- ram_rd_en_o  out  1  sprite RAM read enable.
- ram_rd_data_i  in  32  sprite RAM read data, valid 1 cycle after address/enable.
- hit_valid_o  out  1  hit record valid.
- hit_ready_i  in  1  renderer accepts hit.
- hit_idx_o  out  7  sprite index.
- hit_word0_o  out  32  attribute word 0, unmodified (addr/mode, X).
- hit_word1_o  out  32  attribute word 1, unmodified (Y, Z, flips, size, palette).
- hit_row_o  out  6  row within sprite = (line - Y) mod 1024, truncated.
- busy_o  out  1  scan in progress.
- done_o  out  1  one-cycle pulse at scan end.
- hit_ovf_o  out  1  MAX_HITS reached this line; held until next accepted line_start_i.
- overrun_o  out  1  sticky: line_start_i arrived while busy; cleared only by reset.

Behaviour:
- Reset: state IDLE; all outputs 0; internal index and hit count 0.
- Word1 fields: Y = [9:0]; Z = [19:18]; height code = [31:30]; height = 8 << code (8/16/32/64).
- Hit condition: Z != 0 AND ((line - Y) mod 1024) < height. The subtraction is 10-bit wrap-around, so sprites with Y near 1023 wrap onto the top lines.
- FSM states: IDLE, RD0, RD1, EVAL, WAIT.
  - IDLE: on line_start_i, latch line_i, index=0, hit count=0, clear hit_ovf_o, busy_o=1, go to RD0.
  - RD0: addr=2*idx, en=1. Go to RD1.
  - RD1: addr=2*idx+1, en=1. Capture word0 next edge. Go to EVAL.
  - EVAL: ram_rd_data_i is word1; evaluate hit.
    - On a hit with the output register empty, or being accepted this cycle: load the output register, assert hit_valid_o next cycle, increment hit count.
    - On a hit with the output register full and not being accepted: go to WAIT and keep word0/word1 in the staging register.
    - On a miss or a loaded hit: advance.
  - WAIT: no RAM reads. When hit_ready_i is sampled high, load the staged hit and advance.
  - Advance: if hit count == MAX_HITS after this hit, set hit_ovf_o and end. Else if idx == NUM_SPRITES-1, end. Else idx++ and go to RD0.
  - End: done_o=1 for one cycle, busy_o=0, return to IDLE. A pending hit_valid_o stays asserted until accepted.
- Output handshake: hit fields stable while hit_valid_o=1 and hit_ready_i=0. Transfer occurs on a cycle where both are high.
- Throughput: 3 cycles per sprite without backpressure. A 128-sprite scan with no stalls takes 384 cycles from line_start_i to done_o.
- ram_rd_en_o is high only in RD0 and RD1. Address is 0 otherwise.
- line_start_i while busy: ignored, scan continues unchanged, overrun_o set.
- line_start_i in the same cycle as done_o: ignored (state still not IDLE), overrun_o set.
- Reset mid-scan: immediate return to IDLE. The pending hit is dropped; hit_valid_o=0 next cycle.

Optional Feature:
- Macro: SPRITE_SCAN_PERF_EN.
- Defined: adds output scan_cycles_o (16 bits). A counter clears on accepted line_start_i and increments every busy cycle, saturating at 0xFFFF. Its value is transferred to scan_cycles_o when done_o pulses. scan_cycles_o resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- All Z=0, line_start_i with line 100 -> no hit_valid_o; done_o exactly 384 cycles after the pulse; hit_ovf_o=0.
- Sprite 5: Y=96, Z=3, height code 1 (16); line 100; ready tied high -> one hit: idx=5, row=4, words match RAM. Repeat with line 112 -> no hit.
- Sprite 0: Y=1020, height 8, Z=1; line 3 -> hit, row=7. Line 4 -> no hit.
- MAX_HITS=4, 10 enabled sprites on line 0, ready high -> exactly 4 hits (idx 0..3), hit_ovf_o=1, done_o immediately after the 4th.
- Two hits with hit_ready_i held low 20 cycles -> hit_valid_o and fields stable; no RAM reads during WAIT; both hits delivered in order after ready rises.
- line_start_i pulsed mid-scan -> scan unaffected, overrun_o=1. Reset asserted mid-WAIT -> busy_o=0, hit_valid_o=0 next cycle.

Source files
------------

// File: rtl/sprite_scan_ctrl.sv
// Per-scanline sprite evaluation sequencer: reads attribute RAM, tests each sprite, streams hits.
// Optional SPRITE_SCAN_PERF_EN adds scan_cycles_o, the busy-cycle count of the last scan.
module sprite_scan_ctrl #(
  parameter int unsigned NUM_SPRITES = 128,
  parameter int unsigned MAX_HITS    = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        line_start_i,
  input  logic [9:0]  line_i,
  output logic [7:0]  ram_rd_addr_o,
  output logic        ram_rd_en_o,
  input  logic [31:0] ram_rd_data_i,
  output logic        hit_valid_o,
  input  logic        hit_ready_i,
  output logic [6:0]  hit_idx_o,
  output logic [31:0] hit_word0_o,
  output logic [31:0] hit_word1_o,
  output logic [5:0]  hit_row_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        hit_ovf_o,
`ifdef SPRITE_SCAN_PERF_EN
  output logic [15:0] scan_cycles_o,
`endif
  output logic        overrun_o
);

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StEval, StWait} state_e;

  state_e      state, state_next;
  logic [6:0]  idx, idx_next;
  logic [7:0]  hit_cnt, hit_cnt_next;
  logic [9:0]  cur_line;
  logic [31:0] word0;
  logic [31:0] stage_w1;

  logic [31:0] w1_sel;
  logic [9:0]  diff;
  logic [6:0]  height;
  logic        hit_now;
  logic        load;
  logic        stage_en;
  logic        advance;
  logic        set_ovf;
  logic        accept;
  logic        start;

  assign accept = hit_valid_o & hit_ready_i;
  assign start  = line_start_i & (state == StIdle);
  assign busy_o = (state != StIdle);

  // In WAIT the candidate comes from the staging register, otherwise straight from RAM.
  assign w1_sel  = (state == StWait) ? stage_w1 : ram_rd_data_i;
  assign diff    = cur_line - w1_sel[9:0];
  assign height  = 7'd8 << w1_sel[31:30];
  assign hit_now = (w1_sel[19:18] != 2'b00) && (diff < {3'b000, height});

  always_comb begin
    state_next    = state;
    idx_next      = idx;
    hit_cnt_next  = hit_cnt;
    load          = 1'b0;
    stage_en      = 1'b0;
    advance       = 1'b0;
    set_ovf       = 1'b0;
    done_o        = 1'b0;
    ram_rd_en_o   = 1'b0;
    ram_rd_addr_o = 8'd0;
    unique case (state)
      StIdle: if (line_start_i) state_next = StRd0;
      StRd0: begin
        ram_rd_en_o   = 1'b1;
        ram_rd_addr_o = {idx, 1'b0};
        state_next    = StRd1;
      end
      StRd1: begin
        ram_rd_en_o   = 1'b1;
        ram_rd_addr_o = {idx, 1'b1};
        state_next    = StEval;
      end
      StEval: begin
        if (!hit_now) begin
          advance = 1'b1;
        end else if (!hit_valid_o || hit_ready_i) begin
          load    = 1'b1;
          advance = 1'b1;
        end else begin
          stage_en   = 1'b1;
          state_next = StWait;
        end
      end
      StWait: begin
        if (hit_ready_i) begin
          load    = 1'b1;
          advance = 1'b1;
        end
      end
      default: state_next = StIdle;
    endcase

    if (load) hit_cnt_next = hit_cnt + 8'd1;

    if (advance) begin
      if (load && (hit_cnt_next == 8'(MAX_HITS))) begin
        set_ovf    = 1'b1;
        done_o     = 1'b1;
        state_next = StIdle;
      end else if (idx == 7'(NUM_SPRITES - 1)) begin
        done_o     = 1'b1;
        state_next = StIdle;
      end else begin
        idx_next   = idx + 7'd1;
        state_next = StRd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= StIdle;
      idx         <= 7'd0;
      hit_cnt     <= 8'd0;
      cur_line    <= 10'd0;
      word0       <= 32'd0;
      stage_w1    <= 32'd0;
      hit_valid_o <= 1'b0;
      hit_idx_o   <= 7'd0;
      hit_word0_o <= 32'd0;
      hit_word1_o <= 32'd0;
      hit_row_o   <= 6'd0;
      hit_ovf_o   <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      hit_cnt <= hit_cnt_next;
      if (start) begin
        cur_line  <= line_i;
        idx       <= 7'd0;
        hit_cnt   <= 8'd0;
        hit_ovf_o <= 1'b0;
      end
      if (line_start_i && (state != StIdle)) overrun_o <= 1'b1;
      if (state == StRd1) word0 <= ram_rd_data_i;
      if (stage_en) stage_w1 <= ram_rd_data_i;
      if (load) begin
        hit_valid_o <= 1'b1;
        hit_idx_o   <= idx;
        hit_word0_o <= word0;
        hit_word1_o <= w1_sel;
        hit_row_o   <= diff[5:0];
      end else if (accept) begin
        hit_valid_o <= 1'b0;
      end
      if (set_ovf) hit_ovf_o <= 1'b1;
    end
  end

`ifdef SPRITE_SCAN_PERF_EN
  logic [15:0] cyc_cnt;
  logic [15:0] cyc_cnt_inc;

  assign cyc_cnt_inc = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_cnt       <= 16'd0;
      scan_cycles_o <= 16'd0;
    end else begin
      if (start) cyc_cnt <= 16'd0;
      else if (busy_o) cyc_cnt <= cyc_cnt_inc;
      // Report includes the done cycle itself.
      if (done_o) scan_cycles_o <= cyc_cnt_inc;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_scan_ctrl.sv
// Directed bench for sprite_scan_ctrl with a behavioural 256x32 RAM and a hit/done monitor.
module tb_sprite_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [9:0]  line;
  logic [7:0]  ram_rd_addr;
  logic        ram_rd_en;
  logic [31:0] ram_rd_data;
  logic        hit_valid;
  logic        hit_ready;
  logic [6:0]  hit_idx;
  logic [31:0] hit_word0;
  logic [31:0] hit_word1;
  logic [5:0]  hit_row;
  logic        busy;
  logic        done;
  logic        hit_ovf;
  logic        overrun;

  sprite_scan_ctrl #(
    .NUM_SPRITES(128),
    .MAX_HITS   (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .line_start_i (line_start),
    .line_i       (line),
    .ram_rd_addr_o(ram_rd_addr),
    .ram_rd_en_o  (ram_rd_en),
    .ram_rd_data_i(ram_rd_data),
    .hit_valid_o  (hit_valid),
    .hit_ready_i  (hit_ready),
    .hit_idx_o    (hit_idx),
    .hit_word0_o  (hit_word0),
    .hit_word1_o  (hit_word1),
    .hit_row_o    (hit_row),
    .busy_o       (busy),
    .done_o       (done),
    .hit_ovf_o    (hit_ovf),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  idx;
    logic [5:0]  row;
    logic [31:0] w0;
    logic [31:0] w1;
  } hit_t;

  logic [31:0] mem [256];
  hit_t        hits[$];
  int          cyc = 0;
  int          start_cyc;
  int          done_cyc;
  bit          done_seen;
  bit          count_rd;
  int          rd_cnt;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  always @(negedge clk) begin
    if (hit_valid && hit_ready) hits.push_back('{hit_idx, hit_row, hit_word0, hit_word1});
    if (done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    if (count_rd && ram_rd_en) rd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_w1(input logic [1:0] hc, input logic [1:0] z,
                                        input logic [9:0] y);
    return {hc, 10'h2AB, z, 8'h5C, y};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic set_sprite(input int n, input logic [31:0] w0, input logic [31:0] w1);
    mem[2*n]   = w0;
    mem[2*n+1] = w1;
  endtask

  task automatic start_line(input logic [9:0] l);
    @(posedge clk); #1;
    hits.delete();
    done_seen  = 1'b0;
    start_cyc  = cyc;
    line_start = 1'b1;
    line       = l;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_seen) check_eq("done_timeout", 64'd0, 64'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    line_start = 1'b0;
    line       = 10'd0;
    hit_ready  = 1'b1;
    count_rd   = 1'b0;
    rd_cnt     = 0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", hit_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ovf", hit_ovf, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_rden", ram_rd_en, 0);
    check_eq("rst_addr", ram_rd_addr, 0);

    // All sprites intersect line 100 but are Z-disabled
    for (int i = 0; i < 128; i++) set_sprite(i, 32'h1000_0000 + i, mk_w1(2'd3, 2'd0, 10'd100));
    start_line(10'd100);
    wait_done(500);
    check_eq("z0_hits", hits.size(), 0);
    check_eq("z0_latency", done_cyc - start_cyc, 384);
    check_eq("z0_ovf", hit_ovf, 0);
    check_eq("z0_busy", busy, 0);

    // Sprite 5, Y=96, height 16
    clear_mem();
    set_sprite(5, 32'hA5A5_0123, mk_w1(2'd1, 2'd3, 10'd96));
    start_line(10'd100);
    wait_done(500);
    check_eq("s5_hits", hits.size(), 1);
    if (hits.size() >= 1) begin
      check_eq("s5_idx", hits[0].idx, 5);
      check_eq("s5_row", hits[0].row, 4);
      check_eq("s5_w0", hits[0].w0, 32'hA5A5_0123);
      check_eq("s5_w1", hits[0].w1, {2'd1, 10'h2AB, 2'd3, 8'h5C, 10'd96});
    end
    check_eq("s5_valid_after", hit_valid, 0);
    start_line(10'd112);
    wait_done(500);
    check_eq("s5_l112_hits", hits.size(), 0);

    // Wrap-around: Y=1020, height 8
    clear_mem();
    set_sprite(0, 32'h0BAD_F00D, mk_w1(2'd0, 2'd1, 10'd1020));
    start_line(10'd3);
    wait_done(500);
    check_eq("wrap_hits", hits.size(), 1);
    if (hits.size() >= 1) begin
      check_eq("wrap_idx", hits[0].idx, 0);
      check_eq("wrap_row", hits[0].row, 7);
    end
    start_line(10'd4);
    wait_done(500);
    check_eq("wrap_l4_hits", hits.size(), 0);

    // Hit limit (MAX_HITS=4) with 10 eligible sprites
    clear_mem();
    for (int i = 0; i < 10; i++) set_sprite(i, 32'h2000_0000 + i, mk_w1(2'd0, 2'd2, 10'd0));
    start_line(10'd0);
    wait_done(500);
    check_eq("max_hits", hits.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (hits.size() > i) check_eq("max_idx", hits[i].idx, i);
    end
    check_eq("max_ovf", hit_ovf, 1);
    check_eq("max_latency", done_cyc - start_cyc, 12);

    // Backpressure: sprites 1 and 2 hit, ready low for a while
    clear_mem();
    set_sprite(1, 32'h1111_AAAA, mk_w1(2'd2, 2'd1, 10'd50));
    set_sprite(2, 32'h2222_BBBB, mk_w1(2'd2, 2'd1, 10'd50));
    hit_ready = 1'b0;
    start_line(10'd60);
    check_eq("ovf_cleared", hit_ovf, 0);
    repeat (12) @(negedge clk);
    rd_cnt   = 0;
    count_rd = 1'b1;
    check_eq("stall_valid", hit_valid, 1);
    check_eq("stall_idx", hit_idx, 1);
    check_eq("stall_row", hit_row, 10);
    repeat (8) @(negedge clk);
    count_rd = 1'b0;
    check_eq("stall_rd", rd_cnt, 0);
    check_eq("stall_busy", busy, 1);
    check_eq("stall_idx2", hit_idx, 1);
    check_eq("stall_w0", hit_word0, 32'h1111_AAAA);
    @(posedge clk); #1;
    hit_ready = 1'b1;
    wait_done(500);
    check_eq("stall_hits", hits.size(), 2);
    if (hits.size() >= 2) begin
      check_eq("stall_first", hits[0].idx, 1);
      check_eq("stall_second", hits[1].idx, 2);
      check_eq("stall_w0_2", hits[1].w0, 32'h2222_BBBB);
      check_eq("stall_row_2", hits[1].row, 10);
    end

    // line_start while busy is ignored
    start_line(10'd60);
    repeat (30) @(posedge clk);
    #1 line_start = 1'b1;
    line = 10'd0;
    @(posedge clk); #1;
    line_start = 1'b0;
    check_eq("ovr_flag", overrun, 1);
    wait_done(500);
    check_eq("ovr_latency", done_cyc - start_cyc, 384);
    check_eq("ovr_hits", hits.size(), 2);

    // Reset in the middle of WAIT
    hit_ready = 1'b0;
    start_line(10'd60);
    repeat (15) @(posedge clk);
    #1 check_eq("rstw_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rstw_busy", busy, 0);
    check_eq("rstw_valid", hit_valid, 0);
    check_eq("rstw_overrun", overrun, 0);
    hit_ready = 1'b1;
    start_line(10'd60);
    wait_done(500);
    check_eq("rstw_rescan_hits", hits.size(), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
